// File: rtl/dmem_dma_pkg.sv
// Shared types and defaults for the dmem_dma block-copy engine.
package dmem_dma_pkg;

  localparam int unsigned DMA_AW = 8;
  localparam int unsigned DMA_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dmem_dma_if.sv
// RAM port bundle between the DMA engine (master) and the data RAM (slave).
interface dmem_dma_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  modport master (output wen, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input wen, input waddr, input wdata, input raddr, output rdata);
endinterface

// File: rtl/dmem_dma_addr_cnt.sv
// Address counter: loads a base address, then increments modulo 2**AW on step.
module dma_addr_cnt #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          step,
  output logic [AW-1:0] addr
);

  // load has priority over step; wrap comes free from the AW-bit add
  always_ff @(posedge clk) begin
    if (rst)       addr <= '0;
    else if (load) addr <= base;
    else if (step) addr <= addr + AW'(1);
  end

endmodule

// File: rtl/dmem_dma.sv
// dmem_dma: block copy SRC->DST over the 256x8 data RAM at one byte per cycle.
// Optional fill mode enabled by defining DMEM_DMA_FILL_EN (adds mode/fill_val).
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int unsigned AW = DMA_AW,
  parameter int unsigned DW = DMA_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic          abort,
`ifdef DMEM_DMA_FILL_EN
  input  logic          mode,
  input  logic [DW-1:0] fill_val,
`endif
  output logic          busy,
  output logic          done,
  output logic          aborted,
  dmem_dma_if.master    mem
);

  logic          fill_in;
  logic [DW-1:0] fill_val_in;

`ifdef DMEM_DMA_FILL_EN
  assign fill_in     = mode;
  assign fill_val_in = fill_val;
`else
  assign fill_in     = 1'b0;
  assign fill_val_in = '0;
`endif

  dma_state_t    state_q, state_d;
  logic [AW-1:0] remain_q;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata_q;
  logic          fill_q, wen_q, wen_d, aborted_q, busy_q, done_q;
  logic          accept_c, abort_c, last_c, rd_step_c, wr_step_c;

  assign accept_c = start && (state_q == ST_IDLE);
  assign abort_c  = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign last_c   = (remain_q == AW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, write slot for the following cycle, and address counter steps
  always_comb begin
    state_d   = state_q;
    wen_d     = 1'b0;
    rd_step_c = 1'b0;
    wr_step_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? ST_DONE : ST_RUN;
          wen_d   = fill_in && (len != '0);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          // copy: every read yields a write next cycle; fill: write while bytes remain
          wen_d     = !fill_q || !last_c;
          rd_step_c = !fill_q && !last_c;
          wr_step_c = wen_q && (!fill_q || !last_c);
          if (last_c) state_d = fill_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, byte counter, status flags and write-data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q  <= '0;
      fill_q    <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
      if (accept_c) begin
        remain_q  <= len;
        fill_q    <= fill_in;
        aborted_q <= 1'b0;
        if (fill_in) wdata_q <= fill_val_in;
      end else begin
        if (state_q == ST_RUN) remain_q <= remain_q - AW'(1);
        if (abort_c)           aborted_q <= 1'b1;
        if (wen_q && !fill_q)  wdata_q <= mem.rdata;
      end
    end
  end

  dma_addr_cnt #(.AW(AW)) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept_c && !fill_in),
    .base (src),
    .step (rd_step_c),
    .addr (raddr)
  );

  dma_addr_cnt #(.AW(AW)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept_c),
    .base (dst),
    .step (wr_step_c),
    .addr (waddr)
  );

  // Abort kills the write of its own cycle; copy data flows straight from the RAM
  assign mem.wen   = wen_q && !abort_c;
  assign mem.waddr = waddr;
  assign mem.raddr = raddr;
  assign mem.wdata = (wen_q && !fill_q) ? mem.rdata : wdata_q;

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma with a 256x8 sync-read RAM and a reference memory model.
module tb_dmem_dma;
  import dmem_dma_pkg::*;

  localparam int unsigned AW = DMA_AW;
  localparam int unsigned DW = DMA_DW;

  typedef struct {
    int   busy_n;
    int   done_n;
    int   done_at;
    int   wr_n;
    int   rchg;
    int   post_busy;
    logic ab;
    bit   timeout;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] len = '0;
`ifdef DMEM_DMA_FILL_EN
  logic          mode = 1'b0;
  logic [DW-1:0] fill_val = '0;
`endif
  logic          busy, done, aborted;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic       bk_we = 1'b0;
  logic [7:0] bk_addr = '0;
  logic [7:0] bk_data = '0;

  dmem_dma_if #(.AW(AW), .DW(DW)) mem ();

  dmem_dma #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .abort    (abort),
`ifdef DMEM_DMA_FILL_EN
    .mode     (mode),
    .fill_val (fill_val),
`endif
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  // RAM model: registered read returns the old value on a same-cycle write
  always @(posedge clk) begin
    if (bk_we)        ram[bk_addr] <= bk_data;
    else if (mem.wen) ram[mem.waddr] <= mem.wdata;
    mem.rdata <= ram[mem.raddr];
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Copy of nw bytes: read k sees every write j with j <= k-2 (write j lands at end of cycle j+1)
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int nw);
    logic [7:0] v [256];
    for (int k = 0; k < nw; k++) begin
      if (k >= 2) ref_mem[8'(d + 8'(k - 2))] = v[k-2];
      v[k] = ref_mem[8'(s + 8'(k))];
    end
    for (int j = (nw >= 2) ? nw - 2 : 0; j < nw; j++) ref_mem[8'(d + 8'(j))] = v[j];
  endtask

  // Issue one request and observe it cycle by cycle; ka = abort cycle, extra = cycle of an ignored start
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int ka, input int extra, output obs_t o);
    logic [7:0] rprev;
    o = '{busy_n: 0, done_n: 0, done_at: -1, wr_n: 0, rchg: 0, post_busy: 0, ab: 1'b0, timeout: 1'b1};
    rprev = '0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      abort = (c == ka);
      if (c == extra) begin
        start = 1'b1; src = 8'hE0; dst = 8'h90; len = 8'd5;
      end else begin
        start = 1'b0;
      end
      #1;
      if (c == 0) rprev = mem.raddr;
      else if (mem.raddr !== rprev) begin o.rchg++; rprev = mem.raddr; end
      if (busy) o.busy_n++;
      if (done) begin o.done_n++; o.done_at = c; o.ab = aborted; end
      if (mem.wen) o.wr_n++;
      if (!busy) begin o.timeout = 1'b0; break; end
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (busy) o.post_busy++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (aborted !== 1'b0)     begin errors++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    checks++; if (mem.wen !== 1'b0)     begin errors++; $display("FAIL reset_wen: got %b want 0", mem.wen); end
    checks++; if (mem.waddr !== 8'h00)  begin errors++; $display("FAIL reset_waddr: got %h want 00", mem.waddr); end
    checks++; if (mem.wdata !== 8'h00)  begin errors++; $display("FAIL reset_wdata: got %h want 00", mem.wdata); end
    checks++; if (mem.raddr !== 8'h00)  begin errors++; $display("FAIL reset_raddr: got %h want 00", mem.raddr); end
  endtask

  task automatic test_copy_basic();
    obs_t o;
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) poke(8'(8'h10 + 8'(i)), exp_b[i]);
    run_xfer(8'h10, 8'h80, 8'd4, -1, -1, o);
    model_copy(8'h10, 8'h80, 4);
    checks++; if (o.timeout)        begin errors++; $display("FAIL basic_timeout: got stuck busy want idle"); end
    checks++; if (o.busy_n !== 6)   begin errors++; $display("FAIL basic_busy: got %0d want 6", o.busy_n); end
    checks++; if (o.done_at !== 5)  begin errors++; $display("FAIL basic_done_at: got %0d want 5", o.done_at); end
    checks++; if (o.done_n !== 1)   begin errors++; $display("FAIL basic_done_n: got %0d want 1", o.done_n); end
    checks++; if (o.ab !== 1'b0)    begin errors++; $display("FAIL basic_aborted: got %b want 0", o.ab); end
    checks++; if (o.wr_n !== 4)     begin errors++; $display("FAIL basic_writes: got %0d want 4", o.wr_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[8'h80 + i] !== exp_b[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h want %h", i, ram[8'h80 + i], exp_b[i]);
      end
    end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL basic_ram: got %0d diffs want 0", ram_diffs()); end
  endtask

  task automatic test_len0();
    obs_t o;
    run_xfer(8'h20, 8'h30, 8'd0, -1, -1, o);
    checks++; if (o.busy_n !== 1)   begin errors++; $display("FAIL len0_busy: got %0d want 1", o.busy_n); end
    checks++; if (o.done_at !== 0)  begin errors++; $display("FAIL len0_done_at: got %0d want 0", o.done_at); end
    checks++; if (o.ab !== 1'b0)    begin errors++; $display("FAIL len0_aborted: got %b want 0", o.ab); end
    checks++; if (o.wr_n !== 0)     begin errors++; $display("FAIL len0_writes: got %0d want 0", o.wr_n); end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL len0_ram: got %0d diffs want 0", ram_diffs()); end
  endtask

  task automatic test_wrap();
    obs_t o;
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) poke(8'(8'hFE + 8'(i)), exp_b[i]);
    run_xfer(8'hFE, 8'hFD, 8'd4, -1, -1, o);
    model_copy(8'hFE, 8'hFD, 4);
    checks++; if (o.busy_n !== 6) begin errors++; $display("FAIL wrap_busy: got %0d want 6", o.busy_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[8'(8'hFD + 8'(i))] !== exp_b[i]) begin
        errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, ram[8'(8'hFD + 8'(i))], exp_b[i]);
      end
    end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL wrap_ram: got %0d diffs want 0", ram_diffs()); end
  endtask

  task automatic test_abort();
    obs_t o;
    // abort in RUN cycle index 4 of 8: writes 0..2 land, the gated write 3 and beyond never happen
    run_xfer(8'h00, 8'h40, 8'd8, 4, 1, o);
    model_copy(8'h00, 8'h40, 3);
    checks++; if (o.busy_n !== 6)    begin errors++; $display("FAIL abort_busy: got %0d want 6", o.busy_n); end
    checks++; if (o.done_at !== 5)   begin errors++; $display("FAIL abort_done_at: got %0d want 5", o.done_at); end
    checks++; if (o.ab !== 1'b1)     begin errors++; $display("FAIL abort_flag: got %b want 1", o.ab); end
    checks++; if (o.wr_n !== 3)      begin errors++; $display("FAIL abort_writes: got %0d want 3", o.wr_n); end
    checks++; if (o.post_busy !== 0) begin errors++; $display("FAIL abort_ignored_start: got %0d busy cycles want 0", o.post_busy); end
    checks++; if (aborted !== 1'b1)  begin errors++; $display("FAIL abort_held: got %b want 1", aborted); end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL abort_ram: got %0d diffs want 0", ram_diffs()); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int dn = 0;
    @(negedge clk);
    start = 1'b1; src = 8'h50; dst = 8'hC0; len = 8'd10;
    @(negedge clk); start = 1'b0;   // RUN cycle 0
    @(negedge clk);                 // RUN cycle 1
    @(negedge clk); rst = 1'b1;     // RUN cycle 2
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (mem.wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen: got %b want 0", mem.wen); end
    for (int c = 0; c < 4; c++) begin
      if (done || mem.wen) dn++;
      @(negedge clk); #1;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", dn); end
    model_copy(8'h50, 8'hC0, 2);
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL rstmid_ram: got %0d diffs want 0", ram_diffs()); end
    run_xfer(8'h50, 8'h60, 8'd5, -1, -1, o);
    model_copy(8'h50, 8'h60, 5);
    checks++; if (o.busy_n !== 7)   begin errors++; $display("FAIL rstmid_after_busy: got %0d want 7", o.busy_n); end
    checks++; if (o.done_at !== 6)  begin errors++; $display("FAIL rstmid_after_done: got %0d want 6", o.done_at); end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL rstmid_after_ram: got %0d diffs want 0", ram_diffs()); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [7:0] s, d, l;
    int ka, eb, ed, ew;
    logic ea;
    for (int i = 0; i < 10; i++) begin
      s = 8'($urandom);
      d = 8'($urandom);
      l = 8'($urandom_range(1, 40));
      if (i == 0) d = 8'(s + 8'd1);
      if (i == 1) begin d = 8'(s + 8'd3); l = 8'd12; end
      ka = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32'(l))) : -1;
      if (ka < 0) begin
        eb = l + 2; ed = l + 1; ew = l; ea = 1'b0;
      end else begin
        eb = ka + 2; ed = ka + 1; ew = (ka > 0) ? ka - 1 : 0; ea = 1'b1;
      end
      run_xfer(s, d, l, ka, -1, o);
      model_copy(s, d, ew);
      checks++; if (o.busy_n !== eb) begin errors++; $display("FAIL rnd%0d_busy: got %0d want %0d", i, o.busy_n, eb); end
      checks++; if (o.done_at !== ed) begin errors++; $display("FAIL rnd%0d_done_at: got %0d want %0d", i, o.done_at, ed); end
      checks++; if (o.wr_n !== ew)   begin errors++; $display("FAIL rnd%0d_writes: got %0d want %0d", i, o.wr_n, ew); end
      checks++; if (o.ab !== ea)     begin errors++; $display("FAIL rnd%0d_aborted: got %b want %b", i, o.ab, ea); end
      checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL rnd%0d_ram: got %0d diffs want 0", i, ram_diffs()); end
    end
  endtask

`ifdef DMEM_DMA_FILL_EN
  task automatic test_fill();
    obs_t o;
    mode = 1'b1; fill_val = 8'h5A;
    run_xfer(8'h33, 8'hF0, 8'd20, -1, -1, o);
    mode = 1'b0;
    for (int j = 0; j < 20; j++) ref_mem[8'(8'hF0 + 8'(j))] = 8'h5A;
    checks++; if (o.busy_n !== 21)  begin errors++; $display("FAIL fill_busy: got %0d want 21", o.busy_n); end
    checks++; if (o.done_at !== 20) begin errors++; $display("FAIL fill_done_at: got %0d want 20", o.done_at); end
    checks++; if (o.wr_n !== 20)    begin errors++; $display("FAIL fill_writes: got %0d want 20", o.wr_n); end
    checks++; if (o.rchg !== 0)     begin errors++; $display("FAIL fill_reads: got %0d raddr moves want 0", o.rchg); end
    checks++; if (ram_diffs() !== 0) begin errors++; $display("FAIL fill_ram: got %0d diffs want 0", ram_diffs()); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    rst = 1'b0;
    #1;
    test_reset();
    test_copy_basic();
    test_len0();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef DMEM_DMA_FILL_EN
    test_fill();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
